// File: rtl/hazard_stall_pipeline_regs.sv
// hazard_stall_pipeline_regs: PC, IF/ID and ID/EX (control/destination slice)
// registers driven by load-use hazard controls and the EX-stage branch redirect.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   PCWrite, IFIDWrite  - hazard detector enables for PC and IF/ID
//   Bolha               - hazard detector bubble request into ID/EX
//   branch_taken/target - EX-stage redirect (flushes IF/ID and ID/EX)
//   imem_instr          - instruction fetched at pc
//   id_ctrl/memread/rd  - decode of the IF/ID instruction
//   pc, IFID_*          - fetch address and IF/ID contents
//   IDEX_*              - ID/EX contents (MemRead/RegisterRt feed the hazard unit)
//   stall_count         - saturating count of bubbles inserted
//   flush_count         - saturating count of redirects taken
module hazard_stall_pipeline_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CTRL_W   = 12,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              Bolha,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic [31:0]       imem_instr,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_memread,
    input  logic [4:0]        id_rd,
    output logic [31:0]       pc,
    output logic [31:0]       IFID_instr,
    output logic [31:0]       IFID_pc,
    output logic              IFID_valid,
    output logic [CTRL_W-1:0] IDEX_ctrl,
    output logic              IDEX_MemRead,
    output logic [4:0]        IDEX_RegisterRt,
    output logic              IDEX_valid,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [31:0]      NOP     = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       ifid_instr_q, ifid_instr_d;
    logic [31:0]       ifid_pc_q, ifid_pc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [CTRL_W-1:0] idex_ctrl_q, idex_ctrl_d;
    logic              idex_memread_q, idex_memread_d;
    logic [4:0]        idex_rt_q, idex_rt_d;
    logic              idex_valid_q, idex_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    always_comb begin
        pc_d           = pc_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_valid_d   = ifid_valid_q;
        idex_ctrl_d    = '0;
        idex_memread_d = 1'b0;
        idex_rt_d      = '0;
        idex_valid_d   = 1'b0;
        stall_cnt_d    = stall_cnt_q;
        flush_cnt_d    = flush_cnt_q;

        if (branch_taken) begin
            // Redirect wins over every hazard control; target is word-aligned.
            pc_d         = {branch_target[31:2], 2'b00};
            ifid_instr_d = NOP;
            ifid_pc_d    = '0;
            ifid_valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + CNT_ONE;
            end
        end else begin
            if (PCWrite) begin
                pc_d = pc_q + 32'd4;
            end
            if (IFIDWrite) begin
                ifid_instr_d = imem_instr;
                ifid_pc_d    = pc_q;
                ifid_valid_d = 1'b1;
            end
            if (Bolha) begin
                if (stall_cnt_q != CNT_MAX) begin
                    stall_cnt_d = stall_cnt_q + CNT_ONE;
                end
            end else if (ifid_valid_q) begin
                idex_ctrl_d    = id_ctrl;
                idex_memread_d = id_memread;
                idex_rt_d      = id_rd;
                idex_valid_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            ifid_instr_q   <= NOP;
            ifid_pc_q      <= '0;
            ifid_valid_q   <= 1'b0;
            idex_ctrl_q    <= '0;
            idex_memread_q <= 1'b0;
            idex_rt_q      <= '0;
            idex_valid_q   <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            pc_q           <= pc_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_valid_q   <= ifid_valid_d;
            idex_ctrl_q    <= idex_ctrl_d;
            idex_memread_q <= idex_memread_d;
            idex_rt_q      <= idex_rt_d;
            idex_valid_q   <= idex_valid_d;
            stall_cnt_q    <= stall_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign pc              = pc_q;
    assign IFID_instr      = ifid_instr_q;
    assign IFID_pc         = ifid_pc_q;
    assign IFID_valid      = ifid_valid_q;
    assign IDEX_ctrl       = idex_ctrl_q;
    assign IDEX_MemRead    = idex_memread_q;
    assign IDEX_RegisterRt = idex_rt_q;
    assign IDEX_valid      = idex_valid_q;
    assign stall_count     = stall_cnt_q;
    assign flush_count     = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_pipeline_regs.sv
// tb_hazard_stall_pipeline_regs: directed vectors with a scoreboard queue;
// the driver pushes the expected post-edge state, a monitor pops and compares.
module tb_hazard_stall_pipeline_regs;

    localparam int CTRL_W = 12;
    localparam int CNT_W  = 4;

    localparam logic [31:0] LW  = 32'h0000_A283; // lw  x5,0(x1)
    localparam logic [31:0] ADD = 32'h0012_8333; // add x6,x5,x1
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       iins;
        logic [31:0]       ipc;
        logic              iv;
        logic [CTRL_W-1:0] ctrl;
        logic              mr;
        logic [4:0]        rt;
        logic              xv;
        logic [CNT_W-1:0]  sc;
        logic [CNT_W-1:0]  fc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              PCWrite, IFIDWrite, Bolha, branch_taken;
    logic [31:0]       branch_target;
    logic [31:0]       imem_instr;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_memread;
    logic [4:0]        id_rd;
    logic [31:0]       pc, IFID_instr, IFID_pc;
    logic              IFID_valid, IDEX_MemRead, IDEX_valid;
    logic [CTRL_W-1:0] IDEX_ctrl;
    logic [4:0]        IDEX_RegisterRt;
    logic [CNT_W-1:0]  stall_count, flush_count;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    hazard_stall_pipeline_regs #(
        .RESET_PC(32'h0000_0100),
        .CTRL_W  (CTRL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PCWrite        (PCWrite),
        .IFIDWrite      (IFIDWrite),
        .Bolha          (Bolha),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_instr     (imem_instr),
        .id_ctrl        (id_ctrl),
        .id_memread     (id_memread),
        .id_rd          (id_rd),
        .pc             (pc),
        .IFID_instr     (IFID_instr),
        .IFID_pc        (IFID_pc),
        .IFID_valid     (IFID_valid),
        .IDEX_ctrl      (IDEX_ctrl),
        .IDEX_MemRead   (IDEX_MemRead),
        .IDEX_RegisterRt(IDEX_RegisterRt),
        .IDEX_valid     (IDEX_valid),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    // Instruction memory and a minimal decoder for the IF/ID instruction.
    assign imem_instr = (pc == 32'h100) ? LW :
                        (pc == 32'h104) ? ADD : {16'hC0DE, pc[15:0]};
    assign id_ctrl    = IFID_instr[31:20];
    assign id_rd      = IFID_instr[11:7];
    assign id_memread = (IFID_instr[6:0] == 7'h03);

    function automatic exp_t mk(
        input logic [31:0] p, input logic [31:0] ii, input logic [31:0] ip,
        input logic iv, input logic [CTRL_W-1:0] c, input logic m,
        input logic [4:0] r, input logic xv,
        input logic [CNT_W-1:0] s, input logic [CNT_W-1:0] f);
        exp_t e;
        e.pc = p; e.iins = ii; e.ipc = ip; e.iv = iv; e.ctrl = c;
        e.mr = m; e.rt = r; e.xv = xv; e.sc = s; e.fc = f;
        return e;
    endfunction

    task automatic step(input logic r, input logic pw, input logic iw,
                        input logic b, input logic br,
                        input logic [31:0] tgt, input exp_t e);
        @(negedge clk);
        rst = r; PCWrite = pw; IFIDWrite = iw; Bolha = b;
        branch_taken = br; branch_target = tgt;
        @(posedge clk);
        exp_q.push_back(e);
    endtask

    // Monitor: every registered output is valid one half-cycle after the edge.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = mk(pc, IFID_instr, IFID_pc, IFID_valid, IDEX_ctrl,
                       IDEX_MemRead, IDEX_RegisterRt, IDEX_valid,
                       stall_count, flush_count);
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d state: got pc=%h ifid=%h/%h/%b idex=%h/%b/%0d/%b sc=%0d fc=%0d, need pc=%h ifid=%h/%h/%b idex=%h/%b/%0d/%b sc=%0d fc=%0d",
                             vectors, a.pc, a.iins, a.ipc, a.iv, a.ctrl,
                             a.mr, a.rt, a.xv, a.sc, a.fc, e.pc, e.iins,
                             e.ipc, e.iv, e.ctrl, e.mr, e.rt, e.xv, e.sc,
                             e.fc);
                end
            end
        end
    end

    initial begin
        int s;
        rst = 1'b1; PCWrite = 1'b1; IFIDWrite = 1'b1; Bolha = 1'b0;
        branch_taken = 1'b0; branch_target = '0;

        // Reset for two cycles
        step(1, 1, 1, 0, 0, 0, mk(32'h100, NOP, 0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 1, 1, 0, 0, 0, mk(32'h100, NOP, 0, 0, 0, 0, 0, 0, 0, 0));
        // Fetch lw, then add; lw reaches ID/EX
        step(0, 1, 1, 0, 0, 0, mk(32'h104, LW, 32'h100, 1, 0, 0, 0, 0, 0, 0));
        step(0, 1, 1, 0, 0, 0, mk(32'h108, ADD, 32'h104, 1, 12'h000, 1, 5, 1, 0, 0));
        // Load-use stall: hold PC and IF/ID, bubble ID/EX
        step(0, 0, 0, 1, 0, 0, mk(32'h108, ADD, 32'h104, 1, 0, 0, 0, 0, 1, 0));
        // Resume: add enters ID/EX with rd=6
        step(0, 1, 1, 0, 0, 0, mk(32'h10C, 32'hC0DE0108, 32'h108, 1, 12'h001, 0, 6, 1, 1, 0));
        // Flush beats stall; target low bits cleared
        step(0, 0, 1, 1, 1, 32'h203, mk(32'h200, NOP, 0, 0, 0, 0, 0, 0, 1, 1));
        // PCWrite=0, IFIDWrite=1 re-latches the same pc
        step(0, 0, 1, 0, 0, 0, mk(32'h200, 32'hC0DE0200, 32'h200, 1, 0, 0, 0, 0, 1, 1));
        step(0, 1, 1, 0, 0, 0, mk(32'h204, 32'hC0DE0200, 32'h200, 1, 12'hC0D, 0, 4, 1, 1, 1));
        // IF/ID held while PC advances
        step(0, 1, 0, 0, 0, 0, mk(32'h208, 32'hC0DE0200, 32'h200, 1, 12'hC0D, 0, 4, 1, 1, 1));
        // Branch to top of memory, then wrap
        step(0, 1, 1, 0, 1, 32'hFFFF_FFFF, mk(32'hFFFF_FFFC, NOP, 0, 0, 0, 0, 0, 0, 1, 2));
        step(0, 1, 1, 0, 0, 0, mk(32'h0, 32'hC0DEFFFC, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, 1, 2));
        // Stall counter saturates at 15
        for (int k = 1; k <= 20; k++) begin
            s = (k + 1 > 15) ? 15 : k + 1;
            step(0, 0, 0, 1, 0, 0, mk(32'h0, 32'hC0DEFFFC, 32'hFFFF_FFFC, 1, 0, 0, 0, 0, CNT_W'(s), 2));
        end
        // Reset during a stall and a branch wins over both
        step(1, 0, 0, 1, 1, 32'h300, mk(32'h100, NOP, 0, 0, 0, 0, 0, 0, 0, 0));
        step(0, 1, 1, 0, 0, 0, mk(32'h104, LW, 32'h100, 1, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, need 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
